// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_sequencer
// Description : Prescaled LED pattern sequencer (blink, bounce-walk, count, fill)
// Revision    : 1.0 - initial release
// ============================================================================
module led_sequencer #(
  parameter int NUM_LEDS = 8,
  parameter int TICK_DIV = 50000000,
  parameter int DIV_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [1:0]          mode_i,
  input  logic                mode_valid,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          mode_o,
  output logic                step_o
);

  localparam logic [1:0]          c_mode_blink = 2'd0;
  localparam logic [1:0]          c_mode_walk  = 2'd1;
  localparam logic [1:0]          c_mode_count = 2'd2;
  localparam logic [1:0]          c_mode_fill  = 2'd3;
  localparam logic [DIV_W-1:0]    c_tick_last  = DIV_W'(TICK_DIV - 1);
  localparam logic [NUM_LEDS-1:0] c_led_ones   = {NUM_LEDS{1'b1}};
  localparam logic [NUM_LEDS-1:0] c_led_one    = {{(NUM_LEDS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [DIV_W-1:0]    r_cnt;
  logic [NUM_LEDS-1:0] r_led;
  logic [1:0]          r_mode;
  logic                r_step;
  dir_t                r_dir;

  logic                w_tick;
  logic [NUM_LEDS-1:0] w_led_next;
  dir_t                w_dir_next;
  logic [NUM_LEDS-1:0] w_led_init;

  assign w_tick = enable && (r_cnt == c_tick_last);

  always_comb begin
    w_led_init = '0;
    case (mode_i)
      c_mode_blink: w_led_init = c_led_ones;
      c_mode_walk:  w_led_init = c_led_one;
      default:      w_led_init = '0;
    endcase
  end

  always_comb begin
    w_led_next = r_led;
    w_dir_next = r_dir;
    case (r_mode)
      c_mode_blink: w_led_next = ~r_led;
      c_mode_walk: begin
        // A corrupted (non one-hot) walk pattern restarts from bit 0.
        if (!$onehot(r_led)) begin
          w_led_next = c_led_one;
          w_dir_next = DIR_UP;
        end else if (r_dir == DIR_UP) begin
          if (r_led[NUM_LEDS-1]) begin
            w_led_next = r_led >> 1;
            w_dir_next = DIR_DOWN;
          end else begin
            w_led_next = r_led << 1;
          end
        end else begin
          if (r_led[0]) begin
            w_led_next = r_led << 1;
            w_dir_next = DIR_UP;
          end else begin
            w_led_next = r_led >> 1;
          end
        end
      end
      c_mode_count: w_led_next = r_led + c_led_one;
      c_mode_fill: begin
        if (r_led == c_led_ones) begin
          w_led_next = '0;
        end else begin
          w_led_next = (r_led << 1) | c_led_one;
        end
      end
      default: w_led_next = r_led;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_led  <= c_led_ones;
      r_mode <= c_mode_blink;
      r_step <= 1'b0;
      r_dir  <= DIR_UP;
    end else if (mode_valid) begin
      // A load discards any coincident tick and restarts the step period.
      r_cnt  <= '0;
      r_led  <= w_led_init;
      r_mode <= mode_i;
      r_step <= 1'b0;
      r_dir  <= DIR_UP;
    end else begin
      r_step <= w_tick;
      if (enable) begin
        r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
      end
      if (w_tick) begin
        r_led <= w_led_next;
        r_dir <= w_dir_next;
      end
    end
  end

  assign led    = r_led;
  assign mode_o = r_mode;
  assign step_o = r_step;

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_sequencer
// Description : Directed self-checking bench for led_sequencer (TICK_DIV = 4)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] mode_i;
  logic       mode_valid;
  logic [7:0] led;
  logic [1:0] mode_o;
  logic       step_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0] walk_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  led_sequencer #(
    .NUM_LEDS (8),
    .TICK_DIV (4),
    .DIV_W    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode_i     (mode_i),
    .mode_valid (mode_valid),
    .led        (led),
    .mode_o     (mode_o),
    .step_o     (step_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [1:0] m);
    mode_i     = m;
    mode_valid = 1'b1;
    cycles(1);
    mode_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_led;
    rst = 1'b1; enable = 1'b0; mode_i = 2'd0; mode_valid = 1'b0;
    cycles(2);
    check("rst_led",  32'(led),    32'hFF);
    check("rst_mode", 32'(mode_o), 32'd0);
    check("rst_step", 32'(step_o), 32'd0);
    rst = 1'b0;
    cycles(1);
    check("idle_led", 32'(led), 32'hFF);

    // Blink
    enable = 1'b1;
    cycles(3);
    check("blink_hold_led",  32'(led),    32'hFF);
    check("blink_hold_step", 32'(step_o), 32'd0);
    cycles(1);
    check("blink1_led",  32'(led),    32'h00);
    check("blink1_step", 32'(step_o), 32'd1);
    cycles(1);
    check("blink1_step_end", 32'(step_o), 32'd0);
    cycles(2);
    check("blink1_hold", 32'(led), 32'h00);
    cycles(1);
    check("blink2_led",  32'(led),    32'hFF);
    check("blink2_step", 32'(step_o), 32'd1);

    // Walk bounce
    load(2'd1);
    check("walk_load_led",  32'(led),    32'h01);
    check("walk_load_mode", 32'(mode_o), 32'd1);
    check("walk_load_step", 32'(step_o), 32'd0);
    mode_i = 2'd3;
    for (int i = 0; i < 15; i++) begin
      cycles(3);
      check("walk_pre_step", 32'(step_o), 32'd0);
      cycles(1);
      check("walk_led",  32'(led),    32'(walk_exp[i]));
      check("walk_step", 32'(step_o), 32'd1);
    end
    check("walk_mode_ignored", 32'(mode_o), 32'd1);

    // Pause after two counted cycles
    cycles(2);
    enable = 1'b0;
    cycles(10);
    check("pause_led",  32'(led),    32'h02);
    check("pause_step", 32'(step_o), 32'd0);
    enable = 1'b1;
    cycles(1);
    check("resume1_led",  32'(led),    32'h02);
    check("resume1_step", 32'(step_o), 32'd0);
    cycles(1);
    check("resume2_led",  32'(led),    32'h04);
    check("resume2_step", 32'(step_o), 32'd1);

    // Load coincident with a tick cycle
    cycles(3);
    load(2'd2);
    check("coinc_led",  32'(led),    32'h00);
    check("coinc_mode", 32'(mode_o), 32'd2);
    check("coinc_step", 32'(step_o), 32'd0);

    // Count through full range and wrap
    for (int i = 1; i <= 256; i++) begin
      cycles(4);
      check("count_led",  32'(led),    32'(i % 256));
      check("count_step", 32'(step_o), 32'd1);
    end

    // Fill
    load(2'd3);
    check("fill_load_led",  32'(led),    32'h00);
    check("fill_load_mode", 32'(mode_o), 32'd3);
    mode_i = 2'd1;
    exp_led = 8'h00;
    for (int i = 0; i < 10; i++) begin
      exp_led = (exp_led == 8'hFF) ? 8'h00 : ((exp_led << 1) | 8'h01);
      cycles(4);
      check("fill_led", 32'(led), 32'(exp_led));
    end
    check("fill_mode_ignored", 32'(mode_o), 32'd3);

    // Async reset mid-walk at 8'h20
    load(2'd1);
    cycles(20);
    check("prerst_led", 32'(led), 32'h20);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led",  32'(led),    32'hFF);
    check("async_rst_mode", 32'(mode_o), 32'd0);
    check("async_rst_step", 32'(step_o), 32'd0);
    cycles(1);
    rst = 1'b0;
    cycles(4);
    check("post_rst_blink", 32'(led), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
Pattern controller for the board's user LED bank (8 LEDs on VC707). It divides the free-running board clock into a step tick and advances one of four display patterns on each tick: blink, bounce-walk, binary count, or fill. It sits between the clock buffer and the LED output pins. It replaces per-design ad-hoc blink counters with one sequenced, mode-selectable block.

Parameters:
NUM_LEDS, 8, LED bank width (must be >= 2)
TICK_DIV, 50000000, clock cycles per pattern step (must be >= 2)
DIV_W, 32, prescaler counter width (must satisfy 2^DIV_W > TICK_DIV)

Ports:
clk  input  1  system clock (buffered single-ended board clock)
rst  input  1  reset, asynchronous, active-high
enable  input  1  1 = prescaler runs; 0 = pause (counter and pattern held)
mode_i  input  2  requested mode: 0 BLINK, 1 WALK, 2 COUNT, 3 FILL
mode_valid  input  1  single-cycle strobe; loads mode_i and restarts the pattern
led  output  NUM_LEDS  LED drive, registered
mode_o  output  2  currently active mode, registered
step_o  output  1  one-cycle pulse, high in the cycle the new led value first appears

Behaviour:
- Reset (async assert, sync release):
  - led = all ones, mode_o = 0 (BLINK), prescaler cnt = 0, walk dir = UP, step_o = 0.
- Prescaler:
  - When enable = 1, cnt increments each cycle.
  - tick = enable && (cnt == TICK_DIV-1). On tick, cnt wraps to 0.
  - When enable = 0, cnt holds and no tick occurs.
- Step timing:
  - On the edge that ends a tick cycle, led updates to the next pattern value and step_o registers 1 for exactly one cycle.
  - With continuous enable, led updates every TICK_DIV cycles.
- Next-pattern rules, applied on tick:
  - BLINK: led = ~led.
  - WALK: one-hot bounce, direction FSM with states UP and DOWN.
    - UP: led << 1. When led[NUM_LEDS-1] = 1, go to DOWN and produce led >> 1.
    - DOWN: led >> 1. When led[0] = 1, go to UP and produce led << 1.
  - COUNT: led = led + 1, modulo 2^NUM_LEDS; all ones wraps to 0.
  - FILL: led = (led << 1) | 1. When led is all ones, next value is 0.
- Mode load:
  - On the edge where mode_valid = 1: mode_o = mode_i, cnt = 0, step_o = 0.
  - led is set to the mode's initial value: BLINK all ones, WALK 1 (bit 0), COUNT 0, FILL 0. Walk dir = UP.
  - mode_valid is accepted regardless of enable.
  - mode_valid has priority over a coincident tick: the tick is discarded and no step_o pulse occurs.
  - The first step after a load occurs TICK_DIV enabled cycles later.
- Robustness:
  - A WALK state with led not one-hot (cannot occur after reset or load) recovers to 1 on the next tick.
  - mode_i is ignored when mode_valid = 0.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

Test Plan:
(Bench uses NUM_LEDS = 8, TICK_DIV = 4.)
1. Reset, then enable = 1 -> led = 8'hFF, mode_o = 0. After 4 cycles led = 8'h00 with step_o high for 1 cycle. After 8 cycles led = 8'hFF.
2. mode_valid with mode_i = 1 -> next cycle led = 8'h01. Successive steps: 02, 04, 08, 10, 20, 40, 80, 40, 20, …, 01, 02. step_o pulses every 4 cycles.
3. mode_i = 2 load, run 256 steps -> led counts 00..FF, then wraps to 00 on step 256.
4. mode_i = 3 load -> steps 01, 03, 07, …, FF, 00, 01.
5. WALK, drop enable for 10 cycles after 2 counted cycles -> led and cnt frozen. After re-enable, the step occurs exactly 2 cycles later.
6. Coincident events:
   - mode_valid (mode_i = 2) in a tick cycle -> led = 00, no step_o pulse.
   - Assert rst asynchronously mid-WALK (led = 8'h20) -> led = 8'hFF, mode_o = 0 before the next clock edge.
